inv_shift_row_stage: RTL and testbench

Decryption-pipeline counterpart of the encrypt ShiftRow stage. It registers one AES state and round key per transfer, applies InvShiftRows to the state, and runs the key schedule backward, deriving round key r-1 from round key r. Rcon_out is stepped down by inverse xtime. The stage sits between the decrypt AddRoundKey and InvSubBytes stages. It carries the empty (bubble) flag and adds a 2-entry skid buffer so that downstream back-pressure is absorbed without combinational ready paths.

---
 rtl/aes_pkg.sv | 36 +++
 rtl/aes_sbox.sv | 29 ++
 rtl/inv_shift_row_stage.sv | 133 +++++++++++++
 tb/tb_inv_shift_row_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: byte/word types, the InvShiftRows byte map,
// the inverse-xtime Rcon step and the pipeline entry layout.
package aes_pkg;

   typedef logic [7:0]  byte_t;
   typedef logic [31:0] word_t;

   // Source byte index for each output byte of InvShiftRows (column-major).
   localparam logic [3:0] INV_SHIFT_IDX [16] = '{
      4'h0, 4'hD, 4'hA, 4'h7,
      4'h4, 4'h1, 4'hE, 4'hB,
      4'h8, 4'h5, 4'h2, 4'hF,
      4'hC, 4'h9, 4'h6, 4'h3
   };

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_OUT,
      ST_FULL
   } skid_state_e;

   typedef struct packed {
      byte_t [15:0] r;
      byte_t [15:0] ka;
      byte_t        rcon;
      logic         valid;
   } entry_t;

   function automatic byte_t rcon_inv(input byte_t rc);
      if (rc[0]) begin
         return ((rc ^ 8'h1B) >> 1) | 8'h80;
      end
      return rc >> 1;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational table lookup.
module aes_sbox (
   input  logic [7:0] in_i,
   output logic [7:0] out_o
);

   // Entry 0x00 sits in the most significant byte.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign out_o = SBOX_TABLE[{~in_i, 3'b000} +: 8];

endmodule

// File: rtl/inv_shift_row_stage.sv
// Decrypt pipeline stage: InvShiftRows on the state, one backward key-schedule
// step on the round key, inverse-xtime on Rcon, with an optional skid buffer.
module inv_shift_row_stage
   import aes_pkg::*;
#(
   parameter bit SKID_EN = 1'b1
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [7:0] G0, G1, G2, G3, G4, G5, G6, G7,
   input  logic [7:0] G8, G9, GA, GB, GC, GD, GE, GF,
   input  logic [7:0] K0, K1, K2, K3, K4, K5, K6, K7,
   input  logic [7:0] K8, K9, KA, KB, KC, KD, KE, KF,
   input  logic [7:0] Rcon_in,
   input  logic       empty_in,
   output logic       ready,
   output logic [7:0] R0, R1, R2, R3, R4, R5, R6, R7,
   output logic [7:0] R8, R9, RA, RB, RC, RD, RE, RF,
   output logic [7:0] KA0, KA1, KA2, KA3, KA4, KA5, KA6, KA7,
   output logic [7:0] KA8, KA9, KAA, KAB, KAC, KAD, KAE, KAF,
   output logic [7:0] Rcon_out,
   output logic       empty,
   input  logic       ready_in
);

   byte_t [15:0] g_in;
   byte_t [15:0] k_in;
   byte_t [15:0] r_new;
   byte_t [15:0] ka_new;
   byte_t [3:0]  w3_b;
   byte_t [3:0]  sub_b;
   entry_t       new_e;

   entry_t       out_q, out_d;
   entry_t       skid_q, skid_d;
   skid_state_e  state_q, state_d;
   logic         ready_q, ready_d;
   logic         accept;
   logic         handoff;

   assign g_in = {GF, GE, GD, GC, GB, GA, G9, G8, G7, G6, G5, G4, G3, G2, G1, G0};
   assign k_in = {KF, KE, KD, KC, KB, KA, K9, K8, K7, K6, K5, K4, K3, K2, K1, K0};

   for (genvar i = 0; i < 16; i++) begin : g_inv_shift
      assign r_new[i] = g_in[INV_SHIFT_IDX[i]];
   end

   // Words w1..w3 of the previous key fall out of adjacent XORs; w0 needs
   // SubWord(RotWord(w3)), so the rotation is folded into the S-box wiring.
   for (genvar j = 0; j < 4; j++) begin : g_key_step
      assign w3_b[j] = k_in[12+j] ^ k_in[8+j];

      aes_sbox u_sbox (
         .in_i  (w3_b[(j+1)%4]),
         .out_o (sub_b[j])
      );

      assign ka_new[12+j] = w3_b[j];
      assign ka_new[8+j]  = k_in[8+j] ^ k_in[4+j];
      assign ka_new[4+j]  = k_in[4+j] ^ k_in[j];
      assign ka_new[j]    = k_in[j] ^ sub_b[j] ^ ((j == 0) ? Rcon_in : 8'h00);
   end

   assign new_e = '{r: r_new, ka: ka_new, rcon: rcon_inv(Rcon_in), valid: 1'b1};

   // Without the skid entry, ready is combinational from downstream.
   assign ready   = SKID_EN ? ready_q : (ready_in | ~out_q.valid);
   assign accept  = ~empty_in & ready;
   assign handoff = out_q.valid & ready_in;

   // NOTE: every variable gets its hold value first so no path infers a latch.
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      skid_d  = skid_q;
      unique case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               out_d   = new_e;
               state_d = ST_OUT;
            end
         end
         ST_OUT: begin
            if (accept && handoff) begin
               out_d = new_e;
            end else if (accept) begin
               skid_d  = new_e;
               state_d = ST_FULL;
            end else if (handoff) begin
               out_d.valid = 1'b0;
               state_d     = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (handoff) begin
               out_d        = skid_q;
               skid_d.valid = 1'b0;
               state_d      = ST_OUT;
            end
         end
         default: begin
            out_d.valid  = 1'b0;
            skid_d.valid = 1'b0;
            state_d      = ST_EMPTY;
         end
      endcase
      ready_d = (state_d != ST_FULL);
   end

   // NOTE: sequential state uses non-blocking assignments only.
   // NOTE: the skid data is reset along with the output register so that
   // outputs read 0x00 right after reset and nothing stale survives.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_EMPTY;
         out_q   <= '0;
         skid_q  <= '0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         skid_q  <= skid_d;
         ready_q <= ready_d;
      end
   end

   assign {RF, RE, RD, RC, RB, RA, R9, R8, R7, R6, R5, R4, R3, R2, R1, R0} = out_q.r;
   assign {KAF, KAE, KAD, KAC, KAB, KAA, KA9, KA8,
           KA7, KA6, KA5, KA4, KA3, KA2, KA1, KA0} = out_q.ka;
   assign Rcon_out = out_q.rcon;
   assign empty    = ~out_q.valid;

endmodule

// File: tb/tb_inv_shift_row_stage.sv
// Self-checking bench for inv_shift_row_stage: directed vectors plus random
// handshake traffic compared against a queue-based reference model.
module tb_inv_shift_row_stage;

   logic       clock = 1'b0;
   logic       reset_n;
   logic [7:0] g [16];
   logic [7:0] k [16];
   logic [7:0] rcon_in;
   logic       empty_in;
   logic       ready_in;
   wire        ready;
   wire        empty;
   wire  [7:0] r_w  [16];
   wire  [7:0] ka_w [16];
   wire  [7:0] rcon_out;

   int n_asserts = 0;
   int n_fail    = 0;

   typedef struct {
      logic [127:0] r;
      logic [127:0] ka;
      logic [7:0]   rcon;
   } exp_t;

   exp_t q[$];
   bit   hold = 1'b0;

   always #5 clock = ~clock;

   inv_shift_row_stage #(.SKID_EN(1'b1)) dut (
      .clock(clock), .reset_n(reset_n),
      .G0(g[0]), .G1(g[1]), .G2(g[2]), .G3(g[3]), .G4(g[4]), .G5(g[5]), .G6(g[6]), .G7(g[7]),
      .G8(g[8]), .G9(g[9]), .GA(g[10]), .GB(g[11]), .GC(g[12]), .GD(g[13]), .GE(g[14]), .GF(g[15]),
      .K0(k[0]), .K1(k[1]), .K2(k[2]), .K3(k[3]), .K4(k[4]), .K5(k[5]), .K6(k[6]), .K7(k[7]),
      .K8(k[8]), .K9(k[9]), .KA(k[10]), .KB(k[11]), .KC(k[12]), .KD(k[13]), .KE(k[14]), .KF(k[15]),
      .Rcon_in(rcon_in), .empty_in(empty_in), .ready(ready),
      .R0(r_w[0]), .R1(r_w[1]), .R2(r_w[2]), .R3(r_w[3]), .R4(r_w[4]), .R5(r_w[5]),
      .R6(r_w[6]), .R7(r_w[7]), .R8(r_w[8]), .R9(r_w[9]), .RA(r_w[10]), .RB(r_w[11]),
      .RC(r_w[12]), .RD(r_w[13]), .RE(r_w[14]), .RF(r_w[15]),
      .KA0(ka_w[0]), .KA1(ka_w[1]), .KA2(ka_w[2]), .KA3(ka_w[3]), .KA4(ka_w[4]), .KA5(ka_w[5]),
      .KA6(ka_w[6]), .KA7(ka_w[7]), .KA8(ka_w[8]), .KA9(ka_w[9]), .KAA(ka_w[10]), .KAB(ka_w[11]),
      .KAC(ka_w[12]), .KAD(ka_w[13]), .KAE(ka_w[14]), .KAF(ka_w[15]),
      .Rcon_out(rcon_out), .empty(empty), .ready_in(ready_in)
   );

   // ---------------- reference model ----------------
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // S-box from its definition: GF(2^8) inverse followed by the affine map.
   function automatic logic [7:0] sbox_ref(input logic [7:0] x);
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      if (x != 8'h00) begin
         inv = 8'h01;
         for (int i = 0; i < 254; i++) inv = gmul(inv, x);
      end
      s = 8'h63;
      for (int i = 0; i < 5; i++) s = s ^ ((inv << i) | (inv >> (8 - i)));
      return s;
   endfunction

   // Inverse xtime found by searching for the preimage.
   function automatic logic [7:0] rcon_ref(input logic [7:0] rc);
      logic [7:0] cand;
      for (int i = 0; i < 256; i++) begin
         cand = 8'(i);
         if (xtime(cand) == rc) return cand;
      end
      return 8'h00;
   endfunction

   function automatic logic [127:0] pack16(input logic [7:0] b [16]);
      logic [127:0] res = '0;
      for (int i = 0; i < 16; i++) res = {res[119:0], b[i]};
      return res;
   endfunction

   function automatic exp_t model();
      exp_t         e;
      logic [7:0]   rb [16];
      logic [31:0]  w4, w5, w6, w7, w0, w1, w2, w3, t, sw;
      logic [127:0] kv;
      int           row, col;
      for (int i = 0; i < 16; i++) begin
         row   = i % 4;
         col   = i / 4;
         rb[i] = g[row + 4 * ((col - row + 4) % 4)];
      end
      e.r = pack16(rb);
      kv  = pack16(k);
      {w4, w5, w6, w7} = kv;
      w3 = w7 ^ w6;
      w2 = w6 ^ w5;
      w1 = w5 ^ w4;
      t  = {w3[23:0], w3[31:24]};
      sw = {sbox_ref(t[31:24]), sbox_ref(t[23:16]), sbox_ref(t[15:8]), sbox_ref(t[7:0])};
      w0 = w4 ^ sw ^ {rcon_in, 24'h000000};
      e.ka   = {w0, w1, w2, w3};
      e.rcon = rcon_ref(rcon_in);
      return e;
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_key(input logic [127:0] kv);
      for (int i = 0; i < 16; i++) k[i] = kv[127 - 8*i -: 8];
   endtask

   task automatic cycle();
      bit   acc;
      bit   hof;
      exp_t e;
      acc = !empty_in && (q.size() < 2);
      hof = (q.size() > 0) && ready_in;
      if (acc) e = model();
      @(posedge clock);
      #1;
      if (hof) void'(q.pop_front());
      if (acc) q.push_back(e);
      hold = !empty_in && !acc;
      check("ready", {127'h0, ready}, {127'h0, q.size() < 2});
      check("empty", {127'h0, empty}, {127'h0, q.size() == 0});
      if (q.size() > 0) begin
         check("R", pack16(r_w), q[0].r);
         check("KA", pack16(ka_w), q[0].ka);
         check("Rcon_out", {120'h0, rcon_out}, {120'h0, q[0].rcon});
      end
   endtask

   // Upstream keeps an unaccepted offer stable and valid until it is taken.
   task automatic step(input bit ei, input bit ri, input bit rnd);
      if (hold) begin
         ei = 1'b0;
      end else if (rnd) begin
         for (int i = 0; i < 16; i++) begin
            g[i] = 8'($urandom);
            k[i] = 8'($urandom);
         end
         rcon_in = 8'($urandom);
      end
      empty_in = ei;
      ready_in = ri;
      cycle();
   endtask

   task automatic check_reset_state();
      check("rst_empty", {127'h0, empty}, 128'h1);
      check("rst_ready", {127'h0, ready}, 128'h1);
      check("rst_R", pack16(r_w), 128'h0);
      check("rst_KA", pack16(ka_w), 128'h0);
      check("rst_Rcon", {120'h0, rcon_out}, 128'h0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset_n  = 1'b1;
      empty_in = 1'b1;
      ready_in = 1'b1;
      rcon_in  = 8'h00;
      for (int i = 0; i < 16; i++) begin
         g[i] = 8'h00;
         k[i] = 8'h00;
      end
      #1 reset_n = 1'b0;
      #1 check_reset_state();
      @(posedge clock);
      #1 reset_n = 1'b1;

      // Directed: byte map and FIPS-197 key-schedule vectors
      for (int i = 0; i < 16; i++) g[i] = 8'(i);
      set_key(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      rcon_in = 8'h36;
      step(1'b0, 1'b1, 1'b0);
      check("dir_R", pack16(r_w), 128'h000d0a0704010e0b0805020f0c090603);
      check("dir_KA10", pack16(ka_w), 128'hac7766f319fadc2128d12941575c006e);
      check("dir_Rcon36", {120'h0, rcon_out}, 128'h1b);

      set_key(128'ha0fafe1788542cb123a339392a6c7605);
      rcon_in = 8'h01;
      step(1'b0, 1'b1, 1'b0);
      check("dir_KA1", pack16(ka_w), 128'h2b7e151628aed2a6abf7158809cf4f3c);
      check("dir_Rcon01", {120'h0, rcon_out}, 128'h8d);
      step(1'b1, 1'b1, 1'b1);

      // Back-pressure: A out, B in skid, C held upstream, then drain in order
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1);

      // Alternating bubbles with free-flowing downstream
      for (int i = 0; i < 10; i++) step(1'(i % 2 == 0), 1'b1, 1'b1);

      // Random traffic on both sides of the handshake
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) != 0), 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1);

      // Reset while both entries are occupied
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      check("pre_rst_full", {127'h0, ready}, 128'h0);
      #2 reset_n = 1'b0;
      #1 check_reset_state();
      q.delete();
      hold    = 1'b0;
      reset_n = 1'b1;
      step(1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
